// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: shared state encoding, instruction field constants and the
// decode dispatch used by the cpu_sequencer control unit.
// Latency: n/a (types and constants only). Backpressure: n/a.
package cpu_ctrl_pkg;

  typedef enum logic [5:0] {
    ST_RST,
    ST_IF1,
    ST_IF2,
    ST_UPD_PC,
    ST_DEC,
    ST_MOV_IMM,
    ST_GETA,
    ST_GETB,
    ST_GETB_RD,
    ST_PASS,
    ST_PASS_ST,
    ST_ALU,
    ST_ALU_MVN,
    ST_CMP,
    ST_WR_RD,
    ST_EA,
    ST_LD_ADDR,
    ST_MEM_RD,
    ST_WB_MEM,
    ST_MEM_WR,
    ST_HALT,
    ST_HALT_ILL
  } state_e;

  // opcode = ir[15:13]
  localparam logic [2:0] OPC_MOV  = 3'b110;
  localparam logic [2:0] OPC_ALU  = 3'b101;
  localparam logic [2:0] OPC_LDR  = 3'b011;
  localparam logic [2:0] OPC_STR  = 3'b100;
  localparam logic [2:0] OPC_HALT = 3'b111;

  // op = ir[12:11]
  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_CMP     = 2'b01;
  localparam logic [1:0] OP_AND     = 2'b10;
  localparam logic [1:0] OP_MVN     = 2'b11;
  localparam logic [1:0] OP_MEM     = 2'b00;
  localparam logic [1:0] OP_HALT    = 2'b00;

  localparam logic [1:0] VSEL_MDATA = 2'b00;
  localparam logic [1:0] VSEL_IMM   = 2'b01;
  localparam logic [1:0] VSEL_PC    = 2'b10;
  localparam logic [1:0] VSEL_C     = 2'b11;

  localparam logic [1:0] MEM_NONE  = 2'b00;
  localparam logic [1:0] MEM_READ  = 2'b01;
  localparam logic [1:0] MEM_WRITE = 2'b10;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_MVN = 2'b11;

  // First execute state for a decoded instruction; anything unlisted halts
  // with the illegal flag.
  function automatic state_e dispatch(input logic [2:0] opcode, input logic [1:0] op);
    state_e nxt;
    case ({opcode, op})
      {OPC_MOV, OP_MOV_IMM}: nxt = ST_MOV_IMM;
      {OPC_MOV, OP_MOV_REG}: nxt = ST_GETB;
      {OPC_ALU, OP_ADD},
      {OPC_ALU, OP_CMP},
      {OPC_ALU, OP_AND}:     nxt = ST_GETA;
      {OPC_ALU, OP_MVN}:     nxt = ST_GETB;
      {OPC_LDR, OP_MEM},
      {OPC_STR, OP_MEM}:     nxt = ST_GETA;
      {OPC_HALT, OP_HALT}:   nxt = ST_HALT;
      default:               nxt = ST_HALT_ILL;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/prog_counter.sv
// prog_counter: instruction address register with increment enable.
// Latency: pc updates on the edge where inc=1; wraps from all-ones to 0.
// Backpressure: none. Ports: clk, reset (async high), inc, pc.
module prog_counter #(
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inc,
  output logic [ADDR_W-1:0] pc
);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;

  always_comb begin
    pc_d = pc_q;
    if (inc) begin
      pc_d = (pc_q == {ADDR_W{1'b1}}) ? '0 : pc_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pc_q <= '0;
    else       pc_q <= pc_d;
  end

  assign pc = pc_q;

endmodule

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: fetch/decode/execute control unit owning pc and data_addr;
// drives register-file/ALU controls and a read/write memory handshake.
// Latency: fetch+decode 4 cycles, MOV_IMM 5 .. STR 10; each mem_ready=0 cycle
// in IF1/MEM_RD/MEM_WR stalls one cycle with state and outputs held.
// Ports: clk, reset; ir, datapath_out, mem_ready in; mem_cmd/mem_addr,
// datapath controls, register numbers, sign-extended immediates, status out.
module cpu_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 9,
  parameter int REG_AW = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       ir,
  input  logic [DATA_W-1:0] datapath_out,
  input  logic              mem_ready,
  output logic [1:0]        mem_cmd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              load_ir,
  output logic              loada,
  output logic              loadb,
  output logic              loadc,
  output logic              loads,
  output logic              asel,
  output logic              bsel,
  output logic              write,
  output logic [REG_AW-1:0] readnum,
  output logic [REG_AW-1:0] writenum,
  output logic [1:0]        vsel,
  output logic [1:0]        shift,
  output logic [1:0]        ALUop,
  output logic [DATA_W-1:0] sximm8,
  output logic [DATA_W-1:0] sximm5,
  output logic              halted,
  output logic              illegal
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] data_addr_q, data_addr_d;
  logic [ADDR_W-1:0] pc;
  logic              pc_inc;
  logic              addr_sel;

  logic [2:0]        opcode;
  logic [1:0]        op;
  logic [1:0]        sh;
  logic [REG_AW-1:0] rn, rd, rm;

  assign opcode = ir[15:13];
  assign op     = ir[12:11];
  assign sh     = ir[4:3];
  assign rn     = ir[8 +: REG_AW];
  assign rd     = ir[5 +: REG_AW];
  assign rm     = ir[0 +: REG_AW];

  // Only the low ADDR_W bits of the C register form an address.
  logic unused_dp;
  assign unused_dp = ^{datapath_out, ir};

  prog_counter #(.ADDR_W(ADDR_W)) u_pc (
    .clk   (clk),
    .reset (reset),
    .inc   (pc_inc),
    .pc    (pc)
  );

  // Next state, pc increment and data_addr capture. ir is held by the
  // datapath for the whole instruction, so later states re-read its fields.
  always_comb begin
    state_d     = state_q;
    data_addr_d = data_addr_q;
    pc_inc      = 1'b0;
    case (state_q)
      ST_RST:     state_d = ST_IF1;
      ST_IF1:     if (mem_ready) state_d = ST_IF2;
      ST_IF2:     state_d = ST_UPD_PC;
      ST_UPD_PC: begin
        pc_inc  = 1'b1;
        state_d = ST_DEC;
      end
      ST_DEC:     state_d = dispatch(opcode, op);
      ST_GETA:    state_d = (opcode == OPC_ALU) ? ST_GETB : ST_EA;
      ST_GETB: begin
        if (opcode == OPC_MOV)  state_d = ST_PASS;
        else if (op == OP_CMP)  state_d = ST_CMP;
        else if (op == OP_MVN)  state_d = ST_ALU_MVN;
        else                    state_d = ST_ALU;
      end
      ST_PASS,
      ST_ALU,
      ST_ALU_MVN: state_d = ST_WR_RD;
      ST_EA:      state_d = ST_LD_ADDR;
      ST_LD_ADDR: begin
        data_addr_d = datapath_out[ADDR_W-1:0];
        state_d     = (opcode == OPC_STR) ? ST_GETB_RD : ST_MEM_RD;
      end
      ST_GETB_RD: state_d = ST_PASS_ST;
      ST_PASS_ST: state_d = ST_MEM_WR;
      ST_MEM_RD:  if (mem_ready) state_d = ST_WB_MEM;
      ST_MEM_WR:  if (mem_ready) state_d = ST_IF1;
      ST_MOV_IMM,
      ST_CMP,
      ST_WR_RD,
      ST_WB_MEM:  state_d = ST_IF1;
      ST_HALT,
      ST_HALT_ILL: state_d = state_q;
      default:    state_d = ST_RST;
    endcase
  end

  // Moore outputs decoded from the state register, so reset zeroes them
  // without waiting for a clock edge.
  always_comb begin
    mem_cmd  = MEM_NONE;
    addr_sel = 1'b0;
    load_ir  = 1'b0;
    loada    = 1'b0;
    loadb    = 1'b0;
    loadc    = 1'b0;
    loads    = 1'b0;
    asel     = 1'b0;
    bsel     = 1'b0;
    write    = 1'b0;
    readnum  = '0;
    writenum = '0;
    vsel     = VSEL_MDATA;
    shift    = 2'b00;
    ALUop    = ALU_ADD;
    halted   = 1'b0;
    illegal  = 1'b0;
    sximm8   = '0;
    sximm5   = '0;
    if (state_q != ST_RST) begin
      sximm8 = {{(DATA_W-8){ir[7]}}, ir[7:0]};
      sximm5 = {{(DATA_W-5){ir[4]}}, ir[4:0]};
    end
    case (state_q)
      ST_IF1:     mem_cmd = MEM_READ;
      ST_IF2: begin
        mem_cmd = MEM_READ;
        load_ir = 1'b1;
      end
      ST_MOV_IMM: begin
        writenum = rn;
        vsel     = VSEL_IMM;
        write    = 1'b1;
      end
      ST_GETA: begin
        readnum = rn;
        loada   = 1'b1;
      end
      ST_GETB: begin
        readnum = rm;
        loadb   = 1'b1;
      end
      ST_GETB_RD: begin
        readnum = rd;
        loadb   = 1'b1;
      end
      // A-side forced to zero so the shifted B operand passes through the adder.
      ST_PASS: begin
        asel  = 1'b1;
        shift = sh;
        loadc = 1'b1;
      end
      ST_PASS_ST: begin
        asel  = 1'b1;
        loadc = 1'b1;
      end
      ST_ALU: begin
        ALUop = op;
        shift = sh;
        loadc = 1'b1;
      end
      ST_ALU_MVN: begin
        asel  = 1'b1;
        ALUop = ALU_MVN;
        shift = sh;
        loadc = 1'b1;
      end
      ST_CMP: begin
        ALUop = ALU_SUB;
        shift = sh;
        loads = 1'b1;
      end
      ST_WR_RD: begin
        vsel     = VSEL_C;
        writenum = rd;
        write    = 1'b1;
      end
      ST_EA: begin
        bsel  = 1'b1;
        loadc = 1'b1;
      end
      ST_MEM_RD: begin
        addr_sel = 1'b1;
        mem_cmd  = MEM_READ;
      end
      // Read command and address stay put so memory keeps the data valid.
      ST_WB_MEM: begin
        addr_sel = 1'b1;
        mem_cmd  = MEM_READ;
        vsel     = VSEL_MDATA;
        writenum = rd;
        write    = 1'b1;
      end
      ST_MEM_WR: begin
        addr_sel = 1'b1;
        mem_cmd  = MEM_WRITE;
      end
      ST_HALT:    halted = 1'b1;
      ST_HALT_ILL: begin
        halted  = 1'b1;
        illegal = 1'b1;
      end
      default: ;
    endcase
    mem_addr = addr_sel ? data_addr_q : pc;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_RST;
      data_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      data_addr_q <= data_addr_d;
    end
  end

endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Parametrised instruction sequencer and control unit for the RISC machine. It owns the program counter and the data-address register, and fetches 16-bit instructions from memory through a ready handshake. It decodes MOV, ALU, LDR, STR and HALT, and drives the register-file/ALU datapath control lines. It replaces the externally started decode FSM: execution runs autonomously from reset and has memory access.

## Interface
Parameters:
- DATA_W, 16: datapath width. Must be ≥ 16.
- ADDR_W, 9: memory address width. Must be ≤ DATA_W.
- REG_AW, 3: register-number width. Must be ≤ 3.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- ir  in  16  instruction register contents, held by the datapath
- datapath_out  in  DATA_W  C-register value
- mem_ready  in  1  memory completes the current read/write
- mem_cmd  out  2  00 none, 01 read, 10 write
- mem_addr  out  ADDR_W  PC when addr_sel=0, data_addr when addr_sel=1
- load_ir, loada, loadb, loadc, loads, asel, bsel, write  out  1 each  datapath controls
- readnum, writenum  out  REG_AW  register numbers
- vsel  out  2  00 mdata, 01 sximm8, 10 PC, 11 C
- shift, ALUop  out  2 each  shifter / ALU select
- sximm8, sximm5  out  DATA_W  sign-extended ir[7:0] and ir[4:0]
- halted, illegal  out  1 each  status

## Operation
Instruction fields:
- opcode = ir[15:13], op = ir[12:11]
- Rn = ir[10:8], Rd = ir[7:5], sh = ir[4:3], Rm = ir[2:0]
- Register numbers are truncated to REG_AW bits.

Fetch sequence: RST → IF1 → IF2 → UPD_PC → DEC.
- IF1: mem_cmd=read, addr_sel=0.
- IF2: mem_cmd=read, load_ir=1.
- UPD_PC: pc increments; wraps to 0 at 2^ADDR_W−1.

DEC dispatch (all paths end by returning to IF1):
- 110/10 MOV_IMM: writenum=Rn, vsel=01, write.
- 110/00 MOV_REG: GETB(Rm) → PASS(asel=1, bsel=0, ALUop=00, shift=sh, loadc) → WR_RD(vsel=11, writenum=Rd, write).
- 101/00 ADD, 101/10 AND: GETA(Rn) → GETB(Rm) → ALU(asel=0, bsel=0, ALUop=op, shift=sh, loadc) → WR_RD.
- 101/01 CMP: GETA → GETB → CMP(ALUop=01, shift=sh, loads).
- 101/11 MVN: GETB → ALU(asel=1, ALUop=11, shift=sh, loadc) → WR_RD.
- 011/00 LDR: GETA → EA(asel=0, bsel=1, ALUop=00, loadc) → LD_ADDR(data_addr ← datapath_out[ADDR_W-1:0]) → MEM_RD(addr_sel=1, mem_cmd=read) → WB_MEM(mem_cmd=read, vsel=00, writenum=Rd, write).
- 100/00 STR: GETA → EA → LD_ADDR → GETB_RD(readnum=Rd, loadb) → PASS(shift=00) → MEM_WR(addr_sel=1, mem_cmd=write).
- 111/00 HALT: HALT state, halted=1. Exits only on reset.
- Any other opcode/op: HALT with illegal=1.

Default outputs:
- Every 1-bit control and mem_cmd is 0 in any state that does not name it.
- readnum/writenum default to 0; vsel, shift and ALUop default to 00.
- No X outputs.

## Timing
- Reset asserted: state=RST, pc=0, data_addr=0, all outputs 0 immediately (asynchronous). The first edge after deassertion enters IF1.
- Reset in mid-instruction aborts it. No write is issued after reset assertion.
- IF1, MEM_RD and MEM_WR hold state and outputs while mem_ready=0. They advance on the edge where mem_ready=1.
- The memory holds read data while mem_cmd=read and the address are unchanged. IF2 and WB_MEM rely on this.
- Latency with zero wait states:
  - fetch+decode: 4 cycles
  - MOV_IMM: 5 cycles
  - MOV_REG and MVN: 7 cycles
  - ADD/AND: 8 cycles
  - CMP: 7 cycles
  - LDR: 9 cycles
  - STR: 10 cycles
- Each cycle of mem_ready=0 adds one cycle.
- pc updates only in UPD_PC. data_addr updates only in LD_ADDR.

## Structure
- cpu_ctrl_pkg holds:
  - state enum (6-bit)
  - opcode/op constants
  - vsel, mem_cmd and ALUop constants
- Sub-module prog_counter (ADDR_W): asynchronous reset, increment enable, wrap. data_addr is an in-block register.
- Next-state logic and output logic each live in a single always_comb block.

## Test plan
- Reset released, ir=16'hD205 (MOV R2,#5), mem_ready=1 → after 5 cycles: write=1, writenum=2, vsel=01, sximm8=5; pc=1.
- ir=16'hD0FF → sximm8=16'hFFFF. With DATA_W=32 → 32'hFFFFFFFF.
- ADD ir=16'hA161 (Rn=1, Rd=3, Rm=1): the required sequence is observed:
  - GETA: readnum=1, loada
  - GETB: readnum=1, loadb
  - ALU: loadc, ALUop=00
  - WR_RD: writenum=3, write
- LDR with mem_ready held low 3 cycles in MEM_RD: the state holds. When mem_ready rises, WB_MEM asserts write with vsel=00, and the total is 12 cycles.
- pc reaches 9'h1FF: UPD_PC wraps pc to 0, and the next fetch has mem_addr=0.
- Illegal ir=16'hE800 → HALT with halted=1, illegal=1, mem_cmd=0 forever. Asserting reset mid-STR returns all outputs to 0 at once, and the next fetch is from address 0.
